// File: rtl/param_code_lock.sv
// Parametrised combination-lock controller.
// Collects digits into an entry buffer, compares a full entry against the
// stored code, counts consecutive failures and enforces a timed lockout.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_SET      | waiting for a full-length entry to latch as the new code
// ST_LOCKED   | waiting for a full-length entry to compare against the code
// ST_LOCKOUT  | too many failures; all entry input ignored until timer ends
// ST_UNLOCKED | code accepted; waiting for relock or change_pw
module param_code_lock #(
    parameter int NUM_DIGITS     = 6,
    parameter int DIGIT_W        = 4,
    parameter int DIGIT_MAX      = 9,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int CW             = $clog2(NUM_DIGITS + 1),
    parameter int AW             = $clog2(MAX_ATTEMPTS + 1),
    parameter int TW             = $clog2(LOCKOUT_CYCLES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          digit_valid,
    input  logic                          clear,
    input  logic                          enter,
    input  logic                          relock,
    input  logic                          change_pw,
    output logic [1:0]                    mode,
    output logic                          unlocked,
    output logic [CW-1:0]                 entry_count,
    output logic [NUM_DIGITS*DIGIT_W-1:0] entry_digits,
    output logic [AW-1:0]                 attempts_used,
    output logic [TW-1:0]                 lockout_remaining,
    output logic                          fail_pulse,
    output logic                          reject_pulse
);

    typedef enum logic [1:0] {
        ST_SET      = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_LOCKOUT  = 2'b10,
        ST_UNLOCKED = 2'b11
    } state_e;

    localparam int                  BW         = NUM_DIGITS * DIGIT_W;
    localparam logic [CW-1:0]       FULL_CNT   = CW'(NUM_DIGITS);
    localparam logic [DIGIT_W-1:0]  DIG_LIMIT  = DIGIT_W'(DIGIT_MAX);
    localparam logic [AW-1:0]       ATT_LIMIT  = AW'(MAX_ATTEMPTS);
    localparam logic [TW-1:0]       LOCK_START = TW'(LOCKOUT_CYCLES);

    state_e          mode_q, mode_d;
    logic [BW-1:0]   code_q, code_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   att_q, att_d;
    logic [TW-1:0]   lock_q, lock_d;
    logic            fail_q, fail_d;
    logic            rej_q, rej_d;
    logic [AW-1:0]   att_inc;

    assign att_inc = att_q + AW'(1);

    // State and datapath registers; reset discards the stored code as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= ST_SET;
            code_q <= '0;
            buf_q  <= '0;
            cnt_q  <= '0;
            att_q  <= '0;
            lock_q <= '0;
            fail_q <= 1'b0;
            rej_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            code_q <= code_d;
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            att_q  <= att_d;
            lock_q <= lock_d;
            fail_q <= fail_d;
            rej_q  <= rej_d;
        end
    end

    // Next-state logic; clear outranks enter, which outranks digit_valid.
    always_comb begin
        mode_d = mode_q;
        code_d = code_q;
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        att_d  = att_q;
        lock_d = lock_q;
        fail_d = 1'b0;
        rej_d  = 1'b0;

        unique case (mode_q)
            ST_SET, ST_LOCKED: begin
                if (clear) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (enter) begin
                    if (mode_q == ST_SET) begin
                        // A short entry in SET is ignored and kept for editing.
                        if (cnt_q == FULL_CNT) begin
                            code_d = buf_q;
                            att_d  = '0;
                            mode_d = ST_LOCKED;
                            buf_d  = '0;
                            cnt_d  = '0;
                        end
                    end else begin
                        // Every submission in LOCKED consumes the entry.
                        buf_d = '0;
                        cnt_d = '0;
                        if (cnt_q == FULL_CNT && buf_q == code_q) begin
                            mode_d = ST_UNLOCKED;
                            att_d  = '0;
                        end else begin
                            fail_d = 1'b1;
                            att_d  = att_inc;
                            if (att_inc == ATT_LIMIT) begin
                                mode_d = ST_LOCKOUT;
                                lock_d = LOCK_START;
                            end
                        end
                    end
                end else if (digit_valid) begin
                    if (cnt_q < FULL_CNT && digit_in <= DIG_LIMIT) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (cnt_q == CW'(i)) begin
                                buf_d[i*DIGIT_W +: DIGIT_W] = digit_in;
                            end
                        end
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end

            ST_LOCKOUT: begin
                // Leaving on the 1 -> 0 step makes the lockout exactly LOCKOUT_CYCLES long.
                if (lock_q <= TW'(1)) begin
                    lock_d = '0;
                    mode_d = ST_LOCKED;
                    att_d  = '0;
                    buf_d  = '0;
                    cnt_d  = '0;
                end else begin
                    lock_d = lock_q - TW'(1);
                end
            end

            ST_UNLOCKED: begin
                if (change_pw) begin
                    mode_d = ST_SET;
                    buf_d  = '0;
                    cnt_d  = '0;
                end else if (relock) begin
                    mode_d = ST_LOCKED;
                    buf_d  = '0;
                    cnt_d  = '0;
                end
            end

            default: begin
                mode_d = ST_SET;
            end
        endcase
    end

    assign mode              = mode_q;
    assign unlocked          = (mode_q == ST_UNLOCKED);
    assign entry_count       = cnt_q;
    assign entry_digits      = buf_q;
    assign attempts_used     = att_q;
    assign lockout_remaining = lock_q;
    assign fail_pulse        = fail_q;
    assign reject_pulse      = rej_q;

endmodule

// File: tb/tb_param_code_lock.sv
// Directed bench for param_code_lock: a default-width instance with a short
// lockout, plus a small 4-digit/3-bit instance with a single-attempt limit.
module tb_param_code_lock;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: 6 digits of 4 bits, range 0..9, 3 attempts, 5-cycle lockout.
    logic [3:0]  digit_in;
    logic        digit_valid, clear, enter, relock, change_pw;
    logic [1:0]  mode;
    logic        unlocked;
    logic [2:0]  entry_count;
    logic [23:0] entry_digits;
    logic [1:0]  attempts_used;
    logic [2:0]  lockout_remaining;
    logic        fail_pulse, reject_pulse;

    param_code_lock #(
        .NUM_DIGITS(6), .DIGIT_W(4), .DIGIT_MAX(9), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
        .clear(clear), .enter(enter), .relock(relock), .change_pw(change_pw),
        .mode(mode), .unlocked(unlocked), .entry_count(entry_count),
        .entry_digits(entry_digits), .attempts_used(attempts_used),
        .lockout_remaining(lockout_remaining), .fail_pulse(fail_pulse),
        .reject_pulse(reject_pulse)
    );

    // Instance B: 4 digits of 3 bits, range 0..7, 1 attempt, 3-cycle lockout.
    logic [2:0]  b_digit_in;
    logic        b_digit_valid, b_clear, b_enter, b_relock, b_change_pw;
    logic [1:0]  b_mode;
    logic        b_unlocked;
    logic [2:0]  b_entry_count;
    logic [11:0] b_entry_digits;
    logic [0:0]  b_attempts_used;
    logic [1:0]  b_lockout_remaining;
    logic        b_fail_pulse, b_reject_pulse;

    param_code_lock #(
        .NUM_DIGITS(4), .DIGIT_W(3), .DIGIT_MAX(7), .MAX_ATTEMPTS(1), .LOCKOUT_CYCLES(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .digit_in(b_digit_in), .digit_valid(b_digit_valid),
        .clear(b_clear), .enter(b_enter), .relock(b_relock), .change_pw(b_change_pw),
        .mode(b_mode), .unlocked(b_unlocked), .entry_count(b_entry_count),
        .entry_digits(b_entry_digits), .attempts_used(b_attempts_used),
        .lockout_remaining(b_lockout_remaining), .fail_pulse(b_fail_pulse),
        .reject_pulse(b_reject_pulse)
    );

    // Stimulus helpers: called at a negedge, return at the following negedge.
    task automatic push(input logic [3:0] d);
        digit_in = d; digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic press_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic press_relock();
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
    endtask

    task automatic press_change();
        change_pw = 1'b1;
        @(negedge clk);
        change_pw = 1'b0;
    endtask

    task automatic push6(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        push(a); push(b); push(c); push(d); push(e); push(f);
    endtask

    task automatic b_push(input logic [2:0] d);
        b_digit_in = d; b_digit_valid = 1'b1;
        @(negedge clk);
        b_digit_valid = 1'b0;
    endtask

    task automatic b_press_enter();
        b_enter = 1'b1;
        @(negedge clk);
        b_enter = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", mode); end
        n_checks++; if (unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked: got %b want 0", unlocked); end
        n_checks++; if (entry_count !== 3'd0 || entry_digits !== 24'h0) begin n_fail++; $display("FAIL reset_entry: got %0d/%h want 0/0", entry_count, entry_digits); end
        n_checks++; if (attempts_used !== 2'd0 || lockout_remaining !== 3'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", attempts_used, lockout_remaining); end
        n_checks++; if (fail_pulse !== 1'b0 || reject_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b/%b want 0/0", fail_pulse, reject_pulse); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_set_code();
        push6(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        n_checks++; if (entry_count !== 3'd6) begin n_fail++; $display("FAIL set_count: got %0d want 6", entry_count); end
        n_checks++; if (entry_digits !== 24'h654321) begin n_fail++; $display("FAIL set_digits: got %h want 654321", entry_digits); end
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL set_mode_before_enter: got %b want 00", mode); end
        press_enter();
        n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL set_mode_locked: got %b want 01", mode); end
        n_checks++; if (entry_count !== 3'd0 || attempts_used !== 2'd0) begin n_fail++; $display("FAIL set_after_enter: got cnt %0d att %0d want 0/0", entry_count, attempts_used); end
    endtask

    task automatic test_unlock_change();
        push6(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        press_enter();
        n_checks++; if (mode !== 2'b11 || unlocked !== 1'b1) begin n_fail++; $display("FAIL unlock: got mode %b unlocked %b want 11/1", mode, unlocked); end
        n_checks++; if (fail_pulse !== 1'b0) begin n_fail++; $display("FAIL unlock_no_fail: got %b want 0", fail_pulse); end
        press_relock();
        n_checks++; if (mode !== 2'b01 || unlocked !== 1'b0) begin n_fail++; $display("FAIL relock: got mode %b unlocked %b want 01/0", mode, unlocked); end
        push6(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        press_enter();
        // change_pw and relock together: change_pw wins.
        change_pw = 1'b1; relock = 1'b1;
        @(negedge clk);
        change_pw = 1'b0; relock = 1'b0;
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL change_pw: got %b want 00", mode); end
        push6(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        press_enter();
        n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL new_code_latched: got %b want 01", mode); end
        push6(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        press_enter();
        n_checks++; if (fail_pulse !== 1'b1 || attempts_used !== 2'd1 || mode !== 2'b01) begin n_fail++; $display("FAIL old_code_rejected: got fail %b att %0d mode %b want 1/1/01", fail_pulse, attempts_used, mode); end
        push6(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        press_enter();
        n_checks++; if (mode !== 2'b11 || attempts_used !== 2'd0) begin n_fail++; $display("FAIL new_code_accepted: got mode %b att %0d want 11/0", mode, attempts_used); end
        press_relock();
    endtask

    task automatic test_lockout();
        for (int a = 1; a <= 2; a++) begin
            push6(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
            press_enter();
            n_checks++; if (fail_pulse !== 1'b1 || attempts_used !== 2'(a) || mode !== 2'b01) begin n_fail++; $display("FAIL wrong_code_%0d: got fail %b att %0d mode %b want 1/%0d/01", a, fail_pulse, attempts_used, mode, a); end
        end
        push6(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        press_enter();
        n_checks++; if (fail_pulse !== 1'b1 || mode !== 2'b10 || lockout_remaining !== 3'd5) begin n_fail++; $display("FAIL lockout_entry: got fail %b mode %b rem %0d want 1/10/5", fail_pulse, mode, lockout_remaining); end
        push(4'd3);
        n_checks++; if (entry_count !== 3'd0 || reject_pulse !== 1'b0 || lockout_remaining !== 3'd4) begin n_fail++; $display("FAIL lockout_digit_ignored: got cnt %0d rej %b rem %0d want 0/0/4", entry_count, reject_pulse, lockout_remaining); end
        enter = 1'b1; clear = 1'b1;
        @(negedge clk);
        enter = 1'b0; clear = 1'b0;
        n_checks++; if (fail_pulse !== 1'b0 || mode !== 2'b10 || lockout_remaining !== 3'd3) begin n_fail++; $display("FAIL lockout_enter_ignored: got fail %b mode %b rem %0d want 0/10/3", fail_pulse, mode, lockout_remaining); end
        for (int k = 3; k <= 4; k++) begin
            @(negedge clk);
            n_checks++; if (mode !== 2'b10 || lockout_remaining !== 3'(5 - k)) begin n_fail++; $display("FAIL lockout_tick_%0d: got mode %b rem %0d want 10/%0d", k, mode, lockout_remaining, 5 - k); end
        end
        @(negedge clk);
        n_checks++; if (mode !== 2'b01 || attempts_used !== 2'd0 || lockout_remaining !== 3'd0) begin n_fail++; $display("FAIL lockout_exit: got mode %b att %0d rem %0d want 01/0/0", mode, attempts_used, lockout_remaining); end
    endtask

    task automatic test_reject();
        push6(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        press_enter();
        press_change();
        push6(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        n_checks++; if (reject_pulse !== 1'b0) begin n_fail++; $display("FAIL reject_idle: got %b want 0", reject_pulse); end
        push(4'd7);
        n_checks++; if (reject_pulse !== 1'b1 || entry_count !== 3'd6 || entry_digits !== 24'h654321) begin n_fail++; $display("FAIL reject_full: got rej %b cnt %0d dig %h want 1/6/654321", reject_pulse, entry_count, entry_digits); end
        press_clear();
        n_checks++; if (entry_count !== 3'd0 || entry_digits !== 24'h0 || mode !== 2'b00 || reject_pulse !== 1'b0) begin n_fail++; $display("FAIL clear_set: got cnt %0d dig %h mode %b rej %b want 0/0/00/0", entry_count, entry_digits, mode, reject_pulse); end
        push(4'd12);
        n_checks++; if (reject_pulse !== 1'b1 || entry_count !== 3'd0) begin n_fail++; $display("FAIL reject_range: got rej %b cnt %0d want 1/0", reject_pulse, entry_count); end
        push(4'd9);
        n_checks++; if (reject_pulse !== 1'b0 || entry_count !== 3'd1 || entry_digits !== 24'h000009) begin n_fail++; $display("FAIL accept_max_digit: got rej %b cnt %0d dig %h want 0/1/000009", reject_pulse, entry_count, entry_digits); end
        press_enter();
        n_checks++; if (mode !== 2'b00 || entry_count !== 3'd1) begin n_fail++; $display("FAIL short_enter_set: got mode %b cnt %0d want 00/1", mode, entry_count); end
    endtask

    task automatic test_priority();
        press_clear();
        push6(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        press_enter();
        push6(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        clear = 1'b1; enter = 1'b1; digit_in = 4'd2; digit_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
        n_checks++; if (entry_count !== 3'd0 || entry_digits !== 24'h0 || fail_pulse !== 1'b0 || mode !== 2'b01) begin n_fail++; $display("FAIL priority_clear: got cnt %0d dig %h fail %b mode %b want 0/0/0/01", entry_count, entry_digits, fail_pulse, mode); end
        press_enter();
        n_checks++; if (fail_pulse !== 1'b1 || attempts_used !== 2'd1) begin n_fail++; $display("FAIL empty_enter: got fail %b att %0d want 1/1", fail_pulse, attempts_used); end
        @(negedge clk);
        n_checks++; if (fail_pulse !== 1'b0) begin n_fail++; $display("FAIL fail_one_cycle: got %b want 0", fail_pulse); end
    endtask

    task automatic test_async_reset();
        press_enter();
        press_enter();
        n_checks++; if (mode !== 2'b10 || lockout_remaining !== 3'd5) begin n_fail++; $display("FAIL pre_reset_lockout: got mode %b rem %0d want 10/5", mode, lockout_remaining); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mode !== 2'b00 || lockout_remaining !== 3'd0 || attempts_used !== 2'd0 || entry_count !== 3'd0 || unlocked !== 1'b0) begin n_fail++; $display("FAIL async_reset: got mode %b rem %0d att %0d cnt %0d unl %b want 00/0/0/0/0", mode, lockout_remaining, attempts_used, entry_count, unlocked); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // The stored code is gone: a fresh code can be latched from SET.
        push6(4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4);
        press_enter();
        n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL post_reset_set: got %b want 01", mode); end
    endtask

    task automatic test_small_params();
        b_push(3'd1); b_push(3'd2); b_push(3'd3); b_push(3'd4);
        n_checks++; if (b_entry_count !== 3'd4 || b_entry_digits !== 12'o4321) begin n_fail++; $display("FAIL b_digits: got cnt %0d dig %o want 4/4321", b_entry_count, b_entry_digits); end
        b_press_enter();
        n_checks++; if (b_mode !== 2'b01) begin n_fail++; $display("FAIL b_set: got %b want 01", b_mode); end
        b_push(3'd7);
        n_checks++; if (b_reject_pulse !== 1'b0 || b_entry_count !== 3'd1) begin n_fail++; $display("FAIL b_accept7: got rej %b cnt %0d want 0/1", b_reject_pulse, b_entry_count); end
        b_press_enter();
        n_checks++; if (b_fail_pulse !== 1'b1 || b_mode !== 2'b10 || b_lockout_remaining !== 2'd3 || b_attempts_used !== 1'b1) begin n_fail++; $display("FAIL b_single_fail_lockout: got fail %b mode %b rem %0d att %0d want 1/10/3/1", b_fail_pulse, b_mode, b_lockout_remaining, b_attempts_used); end
        repeat (2) @(negedge clk);
        n_checks++; if (b_mode !== 2'b10 || b_lockout_remaining !== 2'd1) begin n_fail++; $display("FAIL b_lockout_tick: got mode %b rem %0d want 10/1", b_mode, b_lockout_remaining); end
        @(negedge clk);
        n_checks++; if (b_mode !== 2'b01 || b_attempts_used !== 1'b0) begin n_fail++; $display("FAIL b_lockout_exit: got mode %b att %0d want 01/0", b_mode, b_attempts_used); end
        b_push(3'd1); b_push(3'd2); b_push(3'd3); b_push(3'd4);
        b_press_enter();
        n_checks++; if (b_mode !== 2'b11 || b_unlocked !== 1'b1) begin n_fail++; $display("FAIL b_unlock: got mode %b unl %b want 11/1", b_mode, b_unlocked); end
    endtask

    initial begin
        rst_n = 1'b0;
        digit_in = '0; digit_valid = 1'b0; clear = 1'b0; enter = 1'b0; relock = 1'b0; change_pw = 1'b0;
        b_digit_in = '0; b_digit_valid = 1'b0; b_clear = 1'b0; b_enter = 1'b0; b_relock = 1'b0; b_change_pw = 1'b0;
        @(negedge clk);
        test_reset();
        test_set_code();
        test_unlock_change();
        test_lockout();
        test_reject();
        test_priority();
        test_async_reset();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/param_code_lock.md
Name: param_code_lock

Overview:
- Parametrised combination-lock controller; successor to the fixed 6-digit lock FSM.
- Configurable code length, digit width and digit range, attempt limit and a timed lockout.
- Adds explicit digit/clear/enter/relock/change handshakes and exposes entry progress for the 7-segment display driver.
- Sits between the debounced button/switch front end and the display mux.

Parameters:
- NUM_DIGITS, 6, code length in digits (1..8).
- DIGIT_W, 4, bits per digit.
- DIGIT_MAX, 9, largest legal digit value; digit_in > DIGIT_MAX is rejected.
- MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (>=1).
- CW, $clog2(NUM_DIGITS+1), derived width of entry_count.
- AW, $clog2(MAX_ATTEMPTS+1), derived width of attempts_used.
- TW, $clog2(LOCKOUT_CYCLES+1), derived width of lockout_remaining.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- digit_in  in  DIGIT_W  digit value from the switches.
- digit_valid  in  1  one-cycle pulse: push digit_in into the entry buffer.
- clear  in  1  one-cycle pulse: empty the entry buffer.
- enter  in  1  one-cycle pulse: submit the entry buffer.
- relock  in  1  one-cycle pulse: UNLOCKED -> LOCKED, keeping the code.
- change_pw  in  1  one-cycle pulse: UNLOCKED -> SET.
- mode  out  2  00 SET, 01 LOCKED, 10 LOCKOUT, 11 UNLOCKED.
- unlocked  out  1  high iff mode==11.
- entry_count  out  CW  number of digits currently buffered.
- entry_digits  out  NUM_DIGITS*DIGIT_W  buffer contents; digit i in bits [i*DIGIT_W +: DIGIT_W]; first entered digit is i=0; unused slots 0.
- attempts_used  out  AW  consecutive failures since last reset of the count.
- lockout_remaining  out  TW  cycles left in LOCKOUT; 0 otherwise.
- fail_pulse  out  1  one-cycle pulse on each failed attempt.
- reject_pulse  out  1  one-cycle pulse when a digit is dropped (buffer full or out of range).

Behaviour:
- Reset (rst_n low, async): mode=SET, stored code=0, entry buffer and entry_count=0, attempts_used=0, lockout_remaining=0, fail_pulse=0, reject_pulse=0, unlocked=0.
- Simultaneous pulses in one cycle use priority clear > enter > digit_valid; lower-priority pulses that cycle are ignored.
- Digit push, in SET or LOCKED only:
  - If entry_count<NUM_DIGITS and digit_in<=DIGIT_MAX: store into slot entry_count and increment entry_count; visible next cycle.
  - Otherwise: drop the digit and assert reject_pulse next cycle.
- clear: entry buffer and count go to 0; mode and attempts are unchanged.
- Every mode change empties the entry buffer in the same edge.
- SET:
  - enter with entry_count==NUM_DIGITS: latch the buffer as the code, attempts_used=0, mode->LOCKED next cycle.
  - enter with a short entry: ignored, buffer retained.
- LOCKED, on enter:
  - Full buffer equal to the stored code: mode->UNLOCKED next cycle, attempts_used=0.
  - Otherwise, including a short entry: fail_pulse, attempts_used+1.
  - If the new attempts_used==MAX_ATTEMPTS: mode->LOCKOUT, lockout_remaining=LOCKOUT_CYCLES. The fail_pulse and the transition occur on the same edge.
- Entry-to-response latency is exactly 1 cycle.
- LOCKOUT:
  - digit_valid, clear and enter are ignored; rejects are not flagged.
  - lockout_remaining decrements by 1 each cycle.
  - On the edge where it would go from 1 to 0: mode->LOCKED, attempts_used=0. LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- UNLOCKED:
  - Digit, clear and enter are ignored.
  - relock -> LOCKED.
  - change_pw -> SET, stored code retained until a new one is latched.
  - If both arrive in one cycle, change_pw wins.
- relock and change_pw are ignored outside UNLOCKED.
- Reset asserted mid-entry or mid-lockout aborts immediately to the reset state; the stored code is lost.

Test Plan:
- Reset; in SET push 1,2,3,4,5,6 then enter -> mode=01 one cycle later, entry_count=0, attempts_used=0.
- In LOCKED enter 1,2,3,4,5,6 -> mode=11, unlocked=1. Then relock -> mode=01. Then change_pw, enter 6 digits 9,9,9,9,9,9 -> mode=01 and new code accepted, old code fails.
- Three wrong codes (000000) with LOCKOUT_CYCLES=5 -> fail_pulse x3, attempts_used 1,2 then mode=10 and lockout_remaining=5. Digits pushed during lockout are ignored. Exactly 5 cycles later mode=01, attempts_used=0.
- Push 7 digits in SET -> 7th gives reject_pulse, entry_count stays 6. Push digit_in=12 (DIGIT_MAX=9) -> reject_pulse, count unchanged. Short entry plus enter in SET -> no mode change.
- In LOCKED assert clear, enter and digit_valid in the same cycle with 6 digits buffered -> buffer empties, no fail_pulse. Then enter alone with empty buffer -> fail_pulse, attempts_used=1.
- Drop rst_n asynchronously mid-lockout, between clock edges -> all outputs to reset values immediately, mode=00. Re-run with NUM_DIGITS=4, DIGIT_W=3, DIGIT_MAX=7, MAX_ATTEMPTS=1 -> a single failure enters lockout.
